// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: DIGIT full-adder slices per clock, carry kept in a flop,
// WIDTH/DIGIT cycles per operation behind a start/busy/done handshake.
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                 state_q;
  logic [WIDTH-1:0]       a_q;
  logic [WIDTH-1:0]       b_q;
  logic [WIDTH-1:0]       res_q;
  logic                   carry_q;
  logic [CW-1:0]          cnt_q;
  logic                   busy_q;
  logic                   done_q;
  logic [WIDTH-1:0]       sum_q;
  logic                   cout_q;
  logic                   ovf_q;

  logic [DIGIT-1:0]       slice_sum_d;
  logic                   carry_d;
  logic                   cmsb_d;
  logic [WIDTH+DIGIT-1:0] res_cat_d;
  logic [WIDTH-1:0]       res_d;

  // One full-adder slice: returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  // Ripple through the DIGIT slices; cmsb_d ends up as the carry into the top slice,
  // which on the last digit is the carry into the operand MSB.
  always_comb begin
    slice_sum_d = '0;
    carry_d     = carry_q;
    cmsb_d      = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      cmsb_d = carry_d;
      {carry_d, slice_sum_d[i]} = full_add(a_q[i], b_q[i], carry_d);
    end
    res_cat_d = {slice_sum_d, res_q};
    res_d     = res_cat_d[WIDTH+DIGIT-1:DIGIT];
  end

  // Control FSM and datapath registers; results only move on the completion edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= carry_in ^ sub;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          res_q   <= res_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CW'(1'b1);
          if (cnt_q == LAST) begin
            sum_q   <= res_d;
            cout_q  <= carry_d;
            ovf_q   <= carry_d ^ cmsb_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub: one DIGIT=1 and one DIGIT=4 instance, both WIDTH=8,
// checked against an integer-arithmetic reference model.
module tb_serial_add_sub;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         de;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       st_start [2];
  logic       st_sub   [2];
  logic       st_ci    [2];
  logic [7:0] st_a     [2];
  logic [7:0] st_b     [2];
  logic       busy_w   [2];
  logic       done_w   [2];
  logic       cout_w   [2];
  logic       ovf_w    [2];
  logic [7:0] sum_w    [2];
  int         n_pass  = 0;
  int         n_total = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s[inst%0d] t=%0t: got %0h, required %0h", name, k, $time, act, exp);
    else n_pass++;
  endtask

  // Reference result from plain signed/unsigned integer arithmetic.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic s,
                                 input logic ci, input int de);
    exp_t e;
    int ua = a;
    int ub = b;
    int sa = $signed(a);
    int sb = $signed(b);
    int c  = ci;
    int r, sr;
    if (!s) begin
      r      = ua + ub + c;
      sr     = sa + sb + c;
      e.cout = (r > 255);
    end else begin
      r      = ua - ub - c;
      sr     = sa - sb - c;
      e.cout = (ua >= ub + c);
    end
    e.sum = r[7:0];
    e.ovf = (sr > 127) || (sr < -128);
    e.de  = de;
    return e;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int DG = (g == 0) ? 1 : 4;
    localparam int NN = 8 / DG;

    serial_add_sub #(.WIDTH(8), .DIGIT(DG)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (st_start[g]),
      .sub      (st_sub[g]),
      .a        (st_a[g]),
      .b        (st_b[g]),
      .carry_in (st_ci[g]),
      .busy     (busy_w[g]),
      .done     (done_w[g]),
      .sum      (sum_w[g]),
      .carry_out(cout_w[g]),
      .overflow (ovf_w[g])
    );

    exp_t q[$];
    exp_t held = '{sum: 8'h00, cout: 1'b0, ovf: 1'b0, de: 0};
    int   edge_n  = 0;
    int   free_at = 0;

    // Rising edge: model accepts/aborts requests; falling edge: monitor compares.
    always @(clk) begin
      if (clk) begin
        edge_n++;
        if (!rst_n) begin
          q.delete();
          free_at = 0;
          held    = '{sum: 8'h00, cout: 1'b0, ovf: 1'b0, de: 0};
        end else if (st_start[g] && edge_n >= free_at) begin
          q.push_back(model(st_a[g], st_b[g], st_sub[g], st_ci[g], edge_n + NN));
          free_at = edge_n + NN + 1;
        end
      end else if (edge_n > 0) begin
        logic exp_done;
        exp_done = (q.size() > 0) && (q[0].de == edge_n);
        chk("busy", g, 32'(busy_w[g]), 32'(edge_n < free_at - 1));
        chk("done", g, 32'(done_w[g]), 32'(exp_done));
        if (exp_done) held = q.pop_front();
        chk("sum", g, 32'(sum_w[g]), 32'(held.sum));
        chk("carry_out", g, 32'(cout_w[g]), 32'(held.cout));
        chk("overflow", g, 32'(ovf_w[g]), 32'(held.ovf));
      end
    end
  end

  task automatic drive(input int k, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic ci);
    @(negedge clk);
    st_start[k] = 1'b1;
    st_a[k]     = a;
    st_b[k]     = b;
    st_sub[k]   = s;
    st_ci[k]    = ci;
    @(negedge clk);
    st_start[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int t = 0;
    @(negedge clk);
    while (busy_w[k] && t < 40) begin
      @(negedge clk);
      t++;
    end
    n_total++;
    if (busy_w[k]) $display("FAIL wait_idle[inst%0d]: busy still 1, required 0", k);
    else n_pass++;
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      st_start[k] = 1'b1;
      st_a[k]     = 8'($urandom);
      st_b[k]     = 8'($urandom);
      st_sub[k]   = 1'($urandom);
      st_ci[k]    = 1'($urandom);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    st_start[0] = 1'b0;
    st_start[1] = 1'b0;

    wait_idle(0);
    drive(0, 8'hFF, 8'h01, 1'b0, 1'b0);
    wait_idle(0);
    drive(0, 8'h7F, 8'h01, 1'b0, 1'b0);
    wait_idle(0);
    drive(0, 8'h80, 8'h01, 1'b1, 1'b0);
    wait_idle(0);
    drive(0, 8'h05, 8'h07, 1'b1, 1'b1);
    wait_idle(0);
    repeat (5) @(negedge clk);

    // Ignored request while busy, then a request in the done cycle.
    drive(0, 8'h10, 8'h20, 1'b0, 1'b0);
    @(negedge clk);
    drive(0, 8'hAA, 8'h20, 1'b0, 1'b0);
    t = 0;
    while (!done_w[0] && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_total++;
    if (!done_w[0]) $display("FAIL done_wait[inst0]: done 0, required 1");
    else n_pass++;
    st_start[0] = 1'b1;
    st_a[0] = 8'h01;
    st_b[0] = 8'h02;
    st_sub[0] = 1'b0;
    st_ci[0] = 1'b0;
    @(negedge clk);
    st_start[0] = 1'b0;
    wait_idle(0);

    // Abort an operation with reset.
    drive(0, 8'h33, 8'h44, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    drive(1, 8'h9C, 8'h64, 1'b0, 1'b0);
    wait_idle(1);
    drive(1, 8'h80, 8'h01, 1'b1, 1'b0);
    wait_idle(1);

    // Random traffic on both instances, including start-while-busy and occasional reset.
    repeat (600) begin
      @(negedge clk);
      rst_n = ($urandom % 150) != 0;
      for (int k = 0; k < 2; k++) begin
        st_start[k] = ($urandom % 3) != 0;
        st_a[k]     = 8'($urandom);
        st_b[k]     = 8'($urandom);
        st_sub[k]   = 1'($urandom);
        st_ci[k]    = 1'($urandom);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    st_start[0] = 1'b0;
    st_start[1] = 1'b0;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
